// File: rtl/hazard_stall_if.sv
// Pipeline hazard bundle between the core's decode/execute stages and the stall controller.
// Master is the pipeline side; slave is the controller.
interface hazard_stall_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_uses_rs1;
  logic             ID_uses_rs2;
  logic [4:0]       ID_EX_rd;
  logic             ID_EX_MemRead;
  logic             ID_EX_is_mdu;
  logic             mdu_done;
  logic             branch_taken;
  logic             halt_req;
  logic             stall_clr;
  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_write;
  logic             ID_EX_bubble;
  logic             EX_MEM_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_rd, ID_EX_MemRead,
           ID_EX_is_mdu, mdu_done, branch_taken, halt_req, stall_clr,
    input  PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
           EX_MEM_bubble, state, stall_count
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_rd, ID_EX_MemRead,
           ID_EX_is_mdu, mdu_done, branch_taken, halt_req, stall_clr,
    output PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
           EX_MEM_bubble, state, stall_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use, multi-cycle MDU, taken branch
// and external halt, plus a saturating count of cycles in which the PC was held.
module hazard_stall_controller #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          rst_n,
  hazard_stall_if.slave bus
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_WAIT   = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam logic [3:0]       LOAD_INIT = 4'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       lcnt_q;
  logic [3:0]       lcnt_d;
  logic [CNT_W-1:0] count_q;

  logic load_use;
  logic mdu_wait;
  logic pc_w;
  logic ifid_w;
  logic ifid_f;
  logic idex_w;
  logic idex_b;
  logic exmem_b;

  assign load_use = bus.ID_EX_MemRead && (bus.ID_EX_rd != 5'd0) &&
                    ((bus.ID_uses_rs1 && (bus.ID_rs1 == bus.ID_EX_rd)) ||
                     (bus.ID_uses_rs2 && (bus.ID_rs2 == bus.ID_EX_rd)));
  assign mdu_wait = bus.ID_EX_is_mdu && !bus.mdu_done;

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_b  = 1'b0;
    exmem_b = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mdu_wait) begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_w  = 1'b0;
          exmem_b = 1'b1;
          state_d = MDU_WAIT;
        end else if (bus.branch_taken) begin
          ifid_f = 1'b1;
          idex_b = 1'b1;
        end else if (bus.halt_req) begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_b  = 1'b1;
          state_d = HALTED;
        end else if (load_use) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_b = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = LOAD_STALL;
            lcnt_d  = LOAD_INIT;
          end
        end
      end
      LOAD_STALL: begin
        // EX holds a bubble here, so branches cannot resolve and halts wait for RUN.
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_b = 1'b1;
        lcnt_d = lcnt_q - 4'd1;
        if (lcnt_q <= 4'd1) begin
          lcnt_d  = 4'd0;
          state_d = RUN;
        end
      end
      MDU_WAIT: begin
        if (bus.mdu_done) begin
          state_d = RUN;
        end else begin
          pc_w    = 1'b0;
          ifid_w  = 1'b0;
          idex_w  = 1'b0;
          exmem_b = 1'b1;
        end
      end
      HALTED: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        idex_b = 1'b1;
        if (!bus.halt_req) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    // Every enable reads as zero while reset is held.
    if (!rst_n) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      ifid_f  = 1'b0;
      idex_w  = 1'b0;
      idex_b  = 1'b0;
      exmem_b = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (bus.stall_clr) begin
      count_q <= '0;
    end else if (!pc_w && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign bus.PC_write      = pc_w;
  assign bus.IF_ID_write   = ifid_w;
  assign bus.IF_ID_flush   = ifid_f;
  assign bus.ID_EX_write   = idex_w;
  assign bus.ID_EX_bubble  = idex_b;
  assign bus.EX_MEM_bubble = exmem_b;
  assign bus.state         = state_q;
  assign bus.stall_count   = count_q;

endmodule
